matmul_seq: RTL
===============

Name: matmul_seq

Overview:
- Sequencer that computes O = A×B (H×C times C×W, IEEE-754 single precision) by time-sharing one external multiply unit and one external add unit.
- It is the low-area alternative to the fully parallel matrix multiplier and sits between the layer controller and the shared floating-point units.
- It latches the operand matrices and issues one start/done transaction per multiply and per add.
- It accumulates each dot product and presents the completed result matrix with a done pulse.

Parameters:
- S, 32, float width in bits.
- H, 2, rows of A and O.
- W, 2, columns of B and O.
- C, 2, common dimension, C ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- a  in  S*H*C  matrix A, row-major; element n=i*C+k in bits [S*(H*C-n)-1 : S*(H*C-n-1)] (element 0 at MSBs).
- b  in  S*C*W  matrix B, row-major, same packing (n=k*W+j).
- o  out  S*H*W  result O, row-major, same packing (n=i*W+j).
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when O is complete.
- mul_start  out  1  one-cycle pulse to the multiply unit.
- mul_x, mul_y  out  S each  multiply operands.
- mul_o  in  S  product.
- mul_done  in  1  multiply complete (level or pulse).
- add_start  out  1  one-cycle pulse to the add unit.
- add_x, add_y  out  S each  addend operands.
- add_o  in  S  sum.
- add_done  in  1  add complete.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, mul_start, add_start = 0; o, mul_x/y, add_x/y, acc, i/j/k counters = 0.
- Start acceptance: start in IDLE latches a and b into internal registers in the same edge and sets i=j=k=0, busy=1. start while busy is ignored; input changes after acceptance have no effect.
- States: IDLE, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, STORE, FINISH.
- MUL_REQ: drive mul_x=A[i][k], mul_y=B[k][j]; mul_start=1 for exactly one cycle; next MUL_WAIT.
- MUL_WAIT: mul_done is sampled starting the cycle after the mul_start pulse, so a stale done is never taken. On mul_done=1, capture mul_o into prod.
  - If k==0: acc←mul_o, go to STORE-check.
  - Otherwise go to ADD_REQ.
  - No floating-point zero initialisation is used.
- ADD_REQ: add_x=acc, add_y=prod, add_start pulse one cycle; next ADD_WAIT.
- ADD_WAIT: same sampling rule; on add_done: acc←add_o.
- STORE-check (after acc update):
  - If k<C-1: k++, go to MUL_REQ.
  - Else go to STORE.
- STORE: write acc into o element (i,j); k=0; advance j, wrapping to 0 with i++.
  - If (i,j) was (H-1,W-1): go to FINISH.
  - Else: go to MUL_REQ.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. o holds its value until the next STORE of a new operation.
- Operand outputs hold their last values while not requesting; units ignore them without start.
- Transaction count per operation: H*W*C multiplies and H*W*(C-1) adds, strictly serial, never overlapping.
- Cycle overhead with unit latencies Lm, La (start to done): per element C*(Lm+2) + (C-1)*(La+2) + 1 cycles; plus 1 cycle for FINISH.
- C=1: no add transactions; each product is stored directly.
- Elements of o not yet written by the current operation retain previous-operation values (undefined for consumers until done).
- Reset mid-operation aborts immediately: all outputs return to reset values and no done is issued. External units are reset by the same rst_n.
- start asserted in the same cycle as done (FINISH) is ignored; it is accepted one cycle later in IDLE.
- NaN/overflow flags are not consumed; results pass through as produced by the units.

Test Plan:
- Basic 2×2×2 (unit model, Lm=La=3): A=[1,2;3,4]=3F800000,40000000,40400000,40800000; B=[5,6;7,8]=40A00000,40C00000,40E00000,41000000. Required: o=41980000,41B00000,422C0000,42480000; exactly 8 mul_start and 4 add_start pulses; one done pulse; busy low after it.
- Varying latency: same data with random Lm, La in 1..8 and done held high as a level until next start. Required: identical o; no transaction accepted on stale done.
- C=1, H=W=2 (outer product): A=[2;3], B=[4,5]. Required: o=41000000,41200000,41400000,41700000; zero add_start pulses.
- start re-asserted mid-operation with different a/b. Required: ignored; result from the originally latched operands; one done.
- rst_n low during ADD_WAIT of element (1,0). Required: immediate IDLE, all outputs 0, no done. A following start with the basic data gives the basic result.
- Back-to-back: start pulsed on the done cycle, then again next cycle. Required: the first is ignored, the second is accepted; second result correct.

Source files
------------

// File: rtl/matmul_seq.sv
// matmul_seq: computes O = A x B for single-precision float matrices by
// time-sharing one external multiply unit and one external add unit.
// Operands are latched when a request is accepted. Each dot product is
// built from serial multiply/add transactions, one at a time. The result
// matrix is then presented together with a one-cycle done pulse.
module matmul_seq #(
    parameter int S = 32,
    parameter int H = 2,
    parameter int W = 2,
    parameter int C = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [S*H*C-1:0] a,
    input  logic [S*C*W-1:0] b,
    output logic [S*H*W-1:0] o,
    output logic             busy,
    output logic             done,
    output logic             mul_start,
    output logic [S-1:0]     mul_x,
    output logic [S-1:0]     mul_y,
    input  logic [S-1:0]     mul_o,
    input  logic             mul_done,
    output logic             add_start,
    output logic [S-1:0]     add_x,
    output logic [S-1:0]     add_y,
    input  logic [S-1:0]     add_o,
    input  logic             add_done
);

    localparam int IW  = (H > 1) ? $clog2(H) : 1;
    localparam int JW  = (W > 1) ? $clog2(W) : 1;
    localparam int KW  = (C > 1) ? $clog2(C) : 1;
    localparam int AIW = (H * C > 1) ? $clog2(H * C) : 1;
    localparam int BIW = (C * W > 1) ? $clog2(C * W) : 1;
    localparam int OIW = (H * W > 1) ? $clog2(H * W) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(H - 1);
    localparam logic [JW-1:0] J_LAST = JW'(W - 1);
    localparam logic [KW-1:0] K_LAST = KW'(C - 1);

    typedef enum logic [2:0] {
        IDLE,
        MUL_REQ,
        MUL_WAIT,
        ADD_REQ,
        ADD_WAIT,
        STORE,
        FINISH
    } state_t;

    state_t               state;
    logic [S*H*C-1:0]     a_reg;
    logic [S*C*W-1:0]     b_reg;
    logic [IW-1:0]        i;
    logic [JW-1:0]        j;
    logic [KW-1:0]        k;
    logic [S-1:0]         acc;
    logic [S-1:0]         prod;
    logic [S-1:0]         a_mat [H*C];
    logic [S-1:0]         b_mat [C*W];
    logic [S-1:0]         o_mat [H*W];
    logic [AIW-1:0]       a_idx;
    logic [BIW-1:0]       b_idx;
    logic [OIW-1:0]       o_idx;

    // Unpack the latched operand vectors (element 0 sits at the MSBs)
    always_comb begin
        for (int n = 0; n < H * C; n++) begin
            a_mat[n] = a_reg[S*(H*C-n)-1 -: S];
        end
        for (int n = 0; n < C * W; n++) begin
            b_mat[n] = b_reg[S*(C*W-n)-1 -: S];
        end
    end

    // Pack the stored result elements back into the row-major output vector
    always_comb begin
        o = '0;
        for (int n = 0; n < H * W; n++) begin
            o[S*(H*W-n)-1 -: S] = o_mat[n];
        end
    end

    // Flat element indices for A[i][k], B[k][j] and O[i][j]
    always_comb begin
        a_idx = AIW'(int'(i) * C + int'(k));
        b_idx = BIW'(int'(k) * W + int'(j));
        o_idx = OIW'(int'(i) * W + int'(j));
    end

    // Sequencer: walks (i,j,k) and issues one unit transaction at a time.
    // The wait states skip the cycle in which the start pulse is still
    // high, so a done level left over from the previous transaction is
    // never mistaken for the current result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            prod      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mul_start <= 1'b0;
            mul_x     <= '0;
            mul_y     <= '0;
            add_start <= 1'b0;
            add_x     <= '0;
            add_y     <= '0;
            for (int n = 0; n < H * W; n++) begin
                o_mat[n] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= MUL_REQ;
                    end
                end

                MUL_REQ: begin
                    mul_x     <= a_mat[a_idx];
                    mul_y     <= b_mat[b_idx];
                    mul_start <= 1'b1;
                    state     <= MUL_WAIT;
                end

                MUL_WAIT: begin
                    if (mul_start) begin
                        mul_start <= 1'b0;
                    end else if (mul_done) begin
                        prod <= mul_o;
                        if (k == '0) begin
                            // First term of the dot product seeds the accumulator
                            acc <= mul_o;
                            if (k < K_LAST) begin
                                k     <= k + 1'b1;
                                state <= MUL_REQ;
                            end else begin
                                state <= STORE;
                            end
                        end else begin
                            state <= ADD_REQ;
                        end
                    end
                end

                ADD_REQ: begin
                    add_x     <= acc;
                    add_y     <= prod;
                    add_start <= 1'b1;
                    state     <= ADD_WAIT;
                end

                ADD_WAIT: begin
                    if (add_start) begin
                        add_start <= 1'b0;
                    end else if (add_done) begin
                        acc <= add_o;
                        if (k < K_LAST) begin
                            k     <= k + 1'b1;
                            state <= MUL_REQ;
                        end else begin
                            state <= STORE;
                        end
                    end
                end

                STORE: begin
                    o_mat[o_idx] <= acc;
                    k            <= '0;
                    if (j == J_LAST) begin
                        j <= '0;
                        if (i == I_LAST) begin
                            i     <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            i     <= i + 1'b1;
                            state <= MUL_REQ;
                        end
                    end else begin
                        j     <= j + 1'b1;
                        state <= MUL_REQ;
                    end
                end

                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
